// File: rtl/image_ram_ctrl.sv
// image_ram_ctrl
//   Double-buffer controller for a 2*2^BANK_AW x DW image RAM with one write
//   port and one registered (1-cycle) read port. The display reads the front
//   bank while the host fills the back bank; banks swap only on frame_start
//   after the host has committed.
//
//   Optional feature macro: IMAGE_RAM_READBACK_EN
//     defined   : host reads go through the RAM read port (display has priority)
//     undefined : host reads are acked one cycle after accept with zero data
//
// Ports
//   clock, reset          sole clock, synchronous active-high reset
//   host_req/we/addr/wdata host access request (held until host_ack)
//   host_ack, host_rdata  one-cycle completion pulse, read data (held)
//   host_commit           request a bank swap at the next frame_start
//   frame_start           frame boundary pulse from VGA timing
//   disp_en, disp_addr    display read request into the front bank
//   disp_data, disp_valid display read data (= ram_q), valid 2 cycles after disp_en
//   front_bank            bank currently displayed
//   swap_pending          commit seen, swap not yet performed
//   ram_*                 registered RAM write/read port drives, ram_q read data
module image_ram_ctrl #(
  parameter int BANK_AW = 9,
  parameter int DW      = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               host_req,
  input  logic               host_we,
  input  logic [BANK_AW-1:0] host_addr,
  input  logic [DW-1:0]      host_wdata,
  output logic               host_ack,
  output logic [DW-1:0]      host_rdata,
  input  logic               host_commit,
  input  logic               frame_start,
  input  logic               disp_en,
  input  logic [BANK_AW-1:0] disp_addr,
  output logic [DW-1:0]      disp_data,
  output logic               disp_valid,
  output logic               front_bank,
  output logic               swap_pending,
  output logic [BANK_AW:0]   ram_wraddress,
  output logic [DW-1:0]      ram_data,
  output logic               ram_wren,
  output logic [BANK_AW:0]   ram_rdaddress,
  input  logic [DW-1:0]      ram_q
);

`ifdef IMAGE_RAM_READBACK_EN
  typedef enum logic [2:0] {IDLE, WR_DONE, RD_WAIT, RD_ADDR, RD_DATA} state_t;
`else
  typedef enum logic {IDLE, WR_DONE} state_t;
`endif

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_wr_accept;
  logic               w_ack_nxt;
  logic               r_host_ack;
  logic [DW-1:0]      r_host_rdata;
  logic               r_wren;
  logic [BANK_AW:0]   r_wraddress;
  logic [DW-1:0]      r_data;
  logic [BANK_AW:0]   r_rdaddress;
  logic               r_dv1;
  logic               r_dv2;
  logic               r_front_bank;
  logic               r_swap_pending;
`ifdef IMAGE_RAM_READBACK_EN
  logic               w_rd_grant;
  logic               w_rd_done;
`endif

  // Next-state / control. IDLE ignores host_req while host_ack is high: after
  // a read the host still holds host_req in the ack cycle and must not be
  // re-accepted.
  always_comb begin
    w_state_nxt = r_state;
    w_wr_accept = 1'b0;
    w_ack_nxt   = 1'b0;
`ifdef IMAGE_RAM_READBACK_EN
    w_rd_grant  = 1'b0;
    w_rd_done   = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (host_req && !r_host_ack) begin
          if (host_we) begin
            w_wr_accept = 1'b1;
            w_ack_nxt   = 1'b1;
            w_state_nxt = WR_DONE;
          end else begin
`ifdef IMAGE_RAM_READBACK_EN
            if (!disp_en) begin
              w_rd_grant  = 1'b1;
              w_state_nxt = RD_ADDR;
            end else begin
              w_state_nxt = RD_WAIT;
            end
`else
            // No readback path: complete the read immediately with zero data.
            w_ack_nxt   = 1'b1;
            w_state_nxt = WR_DONE;
`endif
          end
        end
      end
      WR_DONE: w_state_nxt = IDLE;
`ifdef IMAGE_RAM_READBACK_EN
      RD_WAIT: begin
        if (!disp_en) begin
          w_rd_grant  = 1'b1;
          w_state_nxt = RD_ADDR;
        end
      end
      RD_ADDR: w_state_nxt = RD_DATA;
      RD_DATA: begin
        w_rd_done   = 1'b1;
        w_ack_nxt   = 1'b1;
        w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_host_ack     <= 1'b0;
      r_host_rdata   <= '0;
      r_wren         <= 1'b0;
      r_wraddress    <= '0;
      r_data         <= '0;
      r_rdaddress    <= '0;
      r_dv1          <= 1'b0;
      r_dv2          <= 1'b0;
      r_front_bank   <= 1'b0;
      r_swap_pending <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_host_ack <= w_ack_nxt;
      r_wren     <= w_wr_accept;

      // Host always targets the back bank as seen at accept time.
      if (w_wr_accept) begin
        r_wraddress <= {~r_front_bank, host_addr};
        r_data      <= host_wdata;
      end

      // Display owns the read port whenever disp_en is high; a host grant
      // only happens in cycles with disp_en low, so the two never collide.
      if (disp_en) begin
        r_rdaddress <= {r_front_bank, disp_addr};
      end
`ifdef IMAGE_RAM_READBACK_EN
      else if (w_rd_grant) begin
        r_rdaddress <= {~r_front_bank, host_addr};
      end

      if (w_rd_done) begin
        r_host_rdata <= ram_q;
      end
`endif

      r_dv1 <= disp_en;
      r_dv2 <= r_dv1;

      // A commit in the frame_start cycle swaps at once and never shows as pending.
      if (frame_start && (r_swap_pending || host_commit)) begin
        r_front_bank   <= ~r_front_bank;
        r_swap_pending <= 1'b0;
      end else if (host_commit) begin
        r_swap_pending <= 1'b1;
      end
    end
  end

  assign host_ack      = r_host_ack;
  assign host_rdata    = r_host_rdata;
  assign disp_data     = ram_q;
  assign disp_valid    = r_dv2;
  assign front_bank    = r_front_bank;
  assign swap_pending  = r_swap_pending;
  assign ram_wraddress = r_wraddress;
  assign ram_data      = r_data;
  assign ram_wren      = r_wren;
  assign ram_rdaddress = r_rdaddress;

endmodule

// File: tb/tb_image_ram_ctrl.sv
// tb_image_ram_ctrl
//   Directed bench for image_ram_ctrl with a behavioural 1024x8 RAM
//   (registered read). Initial RAM pattern: mem[a] = a[7:0] ^ (a[9] ? 8'hF0 : 8'h00).
//   Read-path scenarios follow the IMAGE_RAM_READBACK_EN setting of the build.
module tb_image_ram_ctrl;
  logic       clock = 1'b0;
  logic       reset;
  logic       host_req;
  logic       host_we;
  logic [8:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       host_commit;
  logic       frame_start;
  logic       disp_en;
  logic [8:0] disp_addr;
  logic [7:0] disp_data;
  logic       disp_valid;
  logic       front_bank;
  logic       swap_pending;
  logic [9:0] ram_wraddress;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic [9:0] ram_rdaddress;
  logic [7:0] ram_q;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:1023];

  always #5 clock = ~clock;

  image_ram_ctrl #(.BANK_AW(9), .DW(8)) dut (
    .clock(clock), .reset(reset),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .host_commit(host_commit), .frame_start(frame_start),
    .disp_en(disp_en), .disp_addr(disp_addr), .disp_data(disp_data),
    .disp_valid(disp_valid), .front_bank(front_bank), .swap_pending(swap_pending),
    .ram_wraddress(ram_wraddress), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_rdaddress(ram_rdaddress), .ram_q(ram_q)
  );

  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    host_commit = 0; frame_start = 0; disp_en = 0; disp_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    step(); step();
    reset = 0;
    total++;
    if ({host_ack, host_rdata, disp_valid, front_bank, swap_pending} !== 12'h000) begin
      bad++; $display("FAIL reset_status: got ack=%b rdata=%h dv=%b fb=%b sp=%b want all 0",
                      host_ack, host_rdata, disp_valid, front_bank, swap_pending);
    end
    total++;
    if ({ram_wraddress, ram_data, ram_wren, ram_rdaddress} !== 29'h0) begin
      bad++; $display("FAIL reset_ram: got wa=%h d=%h we=%b ra=%h want all 0",
                      ram_wraddress, ram_data, ram_wren, ram_rdaddress);
    end
  endtask

  task automatic test_write();
    host_req = 1; host_we = 1; host_addr = 9'd3; host_wdata = 8'hA5;
    step();
    host_req = 0;
    total++;
    if (ram_wraddress !== 10'h203 || ram_data !== 8'hA5 || ram_wren !== 1'b1 || host_ack !== 1'b1) begin
      bad++; $display("FAIL write_a5: got wa=%h d=%h we=%b ack=%b want 203 a5 1 1",
                      ram_wraddress, ram_data, ram_wren, host_ack);
    end
    step();
    total++;
    if (ram_wren !== 1'b0 || host_ack !== 1'b0) begin
      bad++; $display("FAIL write_pulse: got we=%b ack=%b want 0 0", ram_wren, host_ack);
    end
  endtask

  task automatic test_display();
    disp_en = 1; disp_addr = 9'd3;
    step();
    disp_en = 0;
    total++;
    if (ram_rdaddress !== 10'h003 || disp_valid !== 1'b0) begin
      bad++; $display("FAIL disp_addr: got ra=%h dv=%b want 003 0", ram_rdaddress, disp_valid);
    end
    step();
    total++;
    if (disp_valid !== 1'b1 || disp_data !== 8'h03) begin
      bad++; $display("FAIL disp_data: got dv=%b d=%h want 1 03", disp_valid, disp_data);
    end
    step();
    total++;
    if (disp_valid !== 1'b0) begin
      bad++; $display("FAIL disp_valid_drop: got %b want 0", disp_valid);
    end
  endtask

  // Three consecutive display reads of 0x010, 0x011, 0x012 -> data 10, 11, 12.
  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h10; exp_d[1] = 8'h11; exp_d[2] = 8'h12;
    for (int i = 0; i < 5; i++) begin
      disp_en   = (i < 3);
      disp_addr = 9'h010 + 9'(i);
      step();
      if (i >= 1 && i <= 3) begin
        total++;
        if (disp_valid !== 1'b1 || disp_data !== exp_d[i-1]) begin
          bad++; $display("FAIL b2b_%0d: got dv=%b d=%h want 1 %h", i-1, disp_valid, disp_data, exp_d[i-1]);
        end
      end
    end
    disp_en = 0;
  endtask

`ifdef IMAGE_RAM_READBACK_EN
  // Read of 0x210 with no display traffic: mem = 10 ^ F0 = E0, ack three cycles later.
  task automatic test_read_uncontested();
    host_req = 1; host_we = 0; host_addr = 9'h010;
    step();
    total++;
    if (ram_rdaddress !== 10'h210 || host_ack !== 1'b0) begin
      bad++; $display("FAIL rd_grant: got ra=%h ack=%b want 210 0", ram_rdaddress, host_ack);
    end
    step();
    total++;
    if (host_ack !== 1'b0) begin
      bad++; $display("FAIL rd_early_ack: got %b want 0", host_ack);
    end
    step();
    total++;
    if (host_ack !== 1'b1 || host_rdata !== 8'hE0) begin
      bad++; $display("FAIL rd_ack: got ack=%b rdata=%h want 1 e0", host_ack, host_rdata);
    end
    host_req = 0;
    step();
    total++;
    if (host_ack !== 1'b0 || host_rdata !== 8'hE0) begin
      bad++; $display("FAIL rd_hold: got ack=%b rdata=%h want 0 e0", host_ack, host_rdata);
    end
  endtask

  // disp_en high 5 cycles while host reads addr 7: mem[0x207] = 07 ^ F0 = F7.
  task automatic test_read_contested();
    int early;
    early = 0;
    host_req = 1; host_we = 0; host_addr = 9'd7;
    disp_en = 1;
    for (int i = 0; i < 5; i++) begin
      disp_addr = 9'h040 + 9'(i);
      step();
      if (host_ack !== 1'b0 || ram_rdaddress[9] !== 1'b0) early++;
    end
    disp_en = 0;
    total++;
    if (early != 0) begin
      bad++; $display("FAIL arb_priority: got %0d cycles with host on read port want 0", early);
    end
    step();
    total++;
    if (ram_rdaddress !== 10'h207) begin
      bad++; $display("FAIL arb_grant: got ra=%h want 207", ram_rdaddress);
    end
    step();
    total++;
    if (host_ack !== 1'b0) begin
      bad++; $display("FAIL arb_early_ack: got %b want 0", host_ack);
    end
    step();
    total++;
    if (host_ack !== 1'b1 || host_rdata !== 8'hF7) begin
      bad++; $display("FAIL arb_ack: got ack=%b rdata=%h want 1 f7", host_ack, host_rdata);
    end
    host_req = 0;
    step();
  endtask
`else
  // Read with display active: acked next cycle with zero, read port stays with display.
  task automatic test_read_disabled();
    host_req = 1; host_we = 0; host_addr = 9'd7;
    disp_en = 1; disp_addr = 9'h055;
    step();
    host_req = 0; disp_en = 0;
    total++;
    if (host_ack !== 1'b1 || host_rdata !== 8'h00) begin
      bad++; $display("FAIL rd_off_ack: got ack=%b rdata=%h want 1 00", host_ack, host_rdata);
    end
    total++;
    if (ram_rdaddress !== 10'h055 || ram_wren !== 1'b0) begin
      bad++; $display("FAIL rd_off_port: got ra=%h we=%b want 055 0", ram_rdaddress, ram_wren);
    end
    step();
    total++;
    if (host_ack !== 1'b0 || ram_rdaddress !== 10'h055) begin
      bad++; $display("FAIL rd_off_after: got ack=%b ra=%h want 0 055", host_ack, ram_rdaddress);
    end
  endtask
`endif

  // Commit sampled at cycle 10, frame_start at cycle 40 (relative).
  task automatic test_swap();
    int drop;
    drop = 0;
    host_commit = 1;
    step();
    host_commit = 0;
    total++;
    if (swap_pending !== 1'b1 || front_bank !== 1'b0) begin
      bad++; $display("FAIL swap_pend_set: got sp=%b fb=%b want 1 0", swap_pending, front_bank);
    end
    for (int i = 0; i < 29; i++) begin
      host_commit = (i == 5);
      step();
      if (swap_pending !== 1'b1 || front_bank !== 1'b0) drop++;
    end
    host_commit = 0;
    total++;
    if (drop != 0) begin
      bad++; $display("FAIL swap_pend_hold: got %0d bad cycles want 0", drop);
    end
    frame_start = 1;
    step();
    frame_start = 0;
    total++;
    if (front_bank !== 1'b1 || swap_pending !== 1'b0) begin
      bad++; $display("FAIL swap_done: got fb=%b sp=%b want 1 0", front_bank, swap_pending);
    end
    host_req = 1; host_we = 1; host_addr = 9'h011; host_wdata = 8'h66;
    step();
    host_req = 0;
    total++;
    if (ram_wraddress !== 10'h011 || ram_wren !== 1'b1) begin
      bad++; $display("FAIL swap_wr_bank: got wa=%h we=%b want 011 1", ram_wraddress, ram_wren);
    end
    step();
  endtask

  // After reset: commit + frame_start + host write + display read all in one cycle.
  task automatic test_swap_same_cycle();
    reset = 1;
    step();
    reset = 0;
    host_commit = 1; frame_start = 1;
    host_req = 1; host_we = 1; host_addr = 9'h022; host_wdata = 8'h3C;
    disp_en = 1; disp_addr = 9'd5;
    step();
    host_commit = 0; frame_start = 0; host_req = 0; disp_en = 0;
    total++;
    if (front_bank !== 1'b1 || swap_pending !== 1'b0) begin
      bad++; $display("FAIL same_swap: got fb=%b sp=%b want 1 0", front_bank, swap_pending);
    end
    total++;
    if (ram_wraddress !== 10'h222 || ram_rdaddress !== 10'h005) begin
      bad++; $display("FAIL same_banks: got wa=%h ra=%h want 222 005", ram_wraddress, ram_rdaddress);
    end
    step();
    total++;
    if (swap_pending !== 1'b0 || front_bank !== 1'b1) begin
      bad++; $display("FAIL same_after: got sp=%b fb=%b want 0 1", swap_pending, front_bank);
    end
  endtask

  // front_bank=1 here. Put activity in flight, then reset.
  task automatic test_reset_midway();
    host_commit = 1;
    step();
    host_commit = 0;
`ifdef IMAGE_RAM_READBACK_EN
    host_req = 1; host_we = 0; host_addr = 9'd4;
    step();
    total++;
    if (ram_rdaddress !== 10'h004) begin
      bad++; $display("FAIL rst_pre_rdaddr: got %h want 004", ram_rdaddress);
    end
`else
    disp_en = 1; disp_addr = 9'h0AA;
    step();
    disp_en = 0;
`endif
    reset = 1; host_req = 0;
    step();
    total++;
    if ({host_ack, host_rdata, disp_valid, front_bank, swap_pending} !== 12'h000) begin
      bad++; $display("FAIL rst_mid_status: got ack=%b rdata=%h dv=%b fb=%b sp=%b want all 0",
                      host_ack, host_rdata, disp_valid, front_bank, swap_pending);
    end
    total++;
    if ({ram_wraddress, ram_data, ram_wren, ram_rdaddress} !== 29'h0) begin
      bad++; $display("FAIL rst_mid_ram: got wa=%h d=%h we=%b ra=%h want all 0",
                      ram_wraddress, ram_data, ram_wren, ram_rdaddress);
    end
    reset = 0;
    step(); step(); step();
    total++;
    if (host_ack !== 1'b0 || disp_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_noack: got ack=%b dv=%b want 0 0", host_ack, disp_valid);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem[a] = 8'(a) ^ ((a >= 512) ? 8'hF0 : 8'h00);
    end
    reset = 1;
    idle_inputs();
    test_reset();
    test_write();
    test_display();
    test_back_to_back();
`ifdef IMAGE_RAM_READBACK_EN
    test_read_uncontested();
    test_read_contested();
`else
    test_read_disabled();
`endif
    test_swap();
    test_swap_same_cycle();
    test_reset_midway();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/image_ram_ctrl.md
# image_ram_ctrl

Double-buffer controller for the 1024×8 image RAM (one write port, one read port with 1-cycle registered read). Splits the RAM into two 512-byte banks: the display reads the front bank while the host fills the back bank. Banks swap only at a frame boundary after the host commits. Sits between the host register interface and the VGA pixel pipeline and drives every RAM port.

## Interface
Parameters:
- `BANK_AW`, default 9: bank address width. RAM address width is `BANK_AW+1`.
- `DW`, default 8: data width.

Ports:
- `clock` in 1: sole clock.
- `reset` in 1: synchronous, active-high.
- `host_req` in 1: host request; held high until `host_ack`.
- `host_we` in 1: 1 = write, 0 = read; sampled with `host_req`.
- `host_addr` in `BANK_AW`: back-bank address.
- `host_wdata` in `DW`: write data.
- `host_ack` out 1: one-cycle completion pulse.
- `host_rdata` out `DW`: read data; valid while `host_ack`=1, held afterwards.
- `host_commit` in 1: pulse; requests a bank swap.
- `frame_start` in 1: pulse from VGA timing.
- `disp_en` in 1: display read request this cycle.
- `disp_addr` in `BANK_AW`: front-bank address.
- `disp_data` out `DW`: equals `ram_q`.
- `disp_valid` out 1: `disp_data` holds the display read issued 2 cycles earlier.
- `front_bank` out 1: bank currently displayed.
- `swap_pending` out 1: commit seen, swap not yet done.
- `ram_wraddress` out `BANK_AW+1`, `ram_data` out `DW`, `ram_wren` out 1, `ram_rdaddress` out `BANK_AW+1`: registered RAM drives.
- `ram_q` in `DW`: RAM read data.

## Operation
- FSM states: IDLE, WR_DONE, RD_WAIT, RD_ADDR, RD_DATA.
- IDLE with `host_req & host_we`:
  - Latch `{~front_bank, host_addr}` and `host_wdata`, go to WR_DONE.
  - In WR_DONE: `ram_wren`=1 and `host_ack`=1 for one cycle, then IDLE.
  - `host_req` is ignored in WR_DONE.
- IDLE with `host_req & ~host_we`:
  - Go to RD_WAIT, or grant directly if `disp_en`=0 in that cycle.
- Read-port arbitration: the display has strict priority.
  - A host read is granted in the first cycle with `disp_en`=0 (IDLE or RD_WAIT).
  - Grant latches `{~front_bank, host_addr}` into `ram_rdaddress` and moves to RD_ADDR.
  - RD_ADDR goes to RD_DATA.
  - RD_DATA registers `ram_q` into `host_rdata`, pulses `host_ack`, returns to IDLE.
- Display read: `disp_en` at cycle N registers `{front_bank, disp_addr}` into `ram_rdaddress`. `disp_valid` is pipelined to match.
- Writes never touch the front bank. Write and read ports operate concurrently.
- Swap logic:
  - `host_commit` sets `swap_pending`.
  - On `frame_start` with (`swap_pending | host_commit`), toggle `front_bank` and clear `swap_pending`.
  - Commit and frame_start in the same cycle swap immediately.
  - Extra commits while pending have no further effect.
- Bank latching:
  - An in-flight host access keeps the bank latched at accept/grant, even across a swap.
  - A display read issued in the swap cycle uses the pre-swap `front_bank`.
- Reset: FSM=IDLE. All outputs are 0, including `front_bank`, `swap_pending`, `host_ack`, `host_rdata`, `disp_valid`, `ram_wren` and both addresses. An in-flight host access is dropped without `host_ack`; the host must reissue it.

## Timing
- Host write: accept at N, then `ram_wren`/`host_ack` at N+1. RAM content is visible to a read issued at N+2 or later.
- Host read, uncontested: accept at N, `ram_rdaddress` at N+1, `ram_q` at N+2, `host_ack`/`host_rdata` at N+3.
- Host read latency with k cycles of `disp_en`=1: 3+k cycles. There is no starvation bound; the display must leave gaps (blanking).
- Display read: `disp_en` at N gives `disp_valid`=1 and `disp_data` valid at N+2. Throughput is one read per cycle.
- `front_bank` changes in the cycle after the `frame_start` edge.

## Configuration
- `IMAGE_RAM_READBACK_EN` defined: host reads behave as above.
- `IMAGE_RAM_READBACK_EN` undefined:
  - A host read is acked at N+1 with `host_rdata`=0.
  - The read port is never driven by the host.
  - States RD_WAIT, RD_ADDR and RD_DATA are removed.

## Test plan
- Reset, then write 0xA5 to addr 3. Required: `ram_wraddress`=0x203, `ram_wren`=1 and `host_ack`=1 one cycle after accept.
- Display reads addr 3 at N with `front_bank`=0. Required: `ram_rdaddress`=0x003 at N+1; `disp_valid`=1 and `disp_data`=`ram_q` at N+2.
- `disp_en` held high 5 cycles during a host read of addr 7. Required: no host grant until `disp_en` falls; `host_ack` at grant+3 with data from RAM addr 0x207.
- `host_commit` at cycle 10, `frame_start` at cycle 40. Required: `swap_pending`=1 for cycles 11–40; `front_bank`=1 at cycle 41; the next host write goes to 0x0xx.
- `host_commit` and `frame_start` in the same cycle. Required: immediate swap, `swap_pending` stays 0. A host write accepted in the swap cycle lands in the old back bank (0x2xx).
- Assert `reset` in RD_ADDR. Required: no `host_ack`, all outputs 0 next cycle, `front_bank`=0. With readback disabled, a read gets `host_ack` at N+1 with `host_rdata`=0x00.
